// File: rtl/ldpc_codeword_assembler.sv
// LDPC codeword assembler: emits all systematic words, then all buffered parity words, on a valid/ready output.
// Optional leading-word puncturing is enabled by defining CODEWORD_ASM_PUNCTURE_EN.
module ldpc_codeword_assembler #(
  parameter int WIDTH           = 8,
  parameter int NUM_SYS_WORDS   = 1024,
  parameter int NUM_PAR_WORDS   = 1024,
  parameter int NUM_PUNCT_WORDS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_sys_data,
  input  logic             i_sys_valid,
  output logic             o_sys_ready,
  input  logic [WIDTH-1:0] i_par_data,
  input  logic             i_par_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic             o_overflow,
  output logic             o_dbg_state
);

  localparam int CNT_MAX = (NUM_SYS_WORDS > NUM_PAR_WORDS) ? NUM_SYS_WORDS : NUM_PAR_WORDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FCNT_W  = $clog2(NUM_PAR_WORDS + 1);
  localparam int PTR_W   = (NUM_PAR_WORDS > 1) ? $clog2(NUM_PAR_WORDS) : 1;

  typedef enum logic {S_SYS, S_PAR} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   mem [NUM_PAR_WORDS];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fcount;
  logic               slot_free, fifo_empty, fifo_full;
  logic               load, load_last, pop, push, punct;
  logic [WIDTH-1:0]   load_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PAR_WORDS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign slot_free   = !o_out_valid | i_out_ready;
  assign fifo_empty  = (fcount == '0);
  assign fifo_full   = (fcount == FCNT_W'(NUM_PAR_WORDS));
  // A full FIFO still accepts a write in the same cycle the head is popped.
  assign push        = i_par_valid & (!fifo_full | pop);
  assign o_dbg_state = (state == S_PAR);

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    o_sys_ready = 1'b0;
    load        = 1'b0;
    load_last   = 1'b0;
    load_data   = mem[rd_ptr];
    pop         = 1'b0;
    punct       = 1'b0;
    case (state)
      S_SYS: begin
`ifdef CODEWORD_ASM_PUNCTURE_EN
        punct = (cnt < CNT_W'(NUM_PUNCT_WORDS));
`endif
        // Punctured words never touch the output register, so they need no free slot.
        o_sys_ready = punct | slot_free;
        if (i_sys_valid && o_sys_ready) begin
          load      = !punct;
          load_data = i_sys_data;
          if (cnt == CNT_W'(NUM_SYS_WORDS - 1)) begin
            cnt_next   = '0;
            state_next = S_PAR;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (!fifo_empty && slot_free) begin
          pop  = 1'b1;
          load = 1'b1;
          if (cnt == CNT_W'(NUM_PAR_WORDS - 1)) begin
            load_last  = 1'b1;
            cnt_next   = '0;
            state_next = S_SYS;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = S_SYS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_SYS;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= i_par_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcount     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fcount <= fcount + FCNT_W'(1);
      else if (pop && !push) fcount <= fcount - FCNT_W'(1);
      if (i_par_valid && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
    end else if (load) begin
      o_out_data  <= load_data;
      o_out_valid <= 1'b1;
      o_out_last  <= load_last;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
    end
  end

endmodule
